// File: rtl/inst_rom_loader_if.sv
// Fetch bus and byte-serial loader stream between the core/loader side and the
// instruction memory responder.
interface inst_rom_loader_if;
    // Loader handshake: a byte moves on a rising edge where ld_valid_i && ld_ready_o;
    // ld_byte_i and ld_last_i are only meaningful on that edge, and ld_ready_o does
    // not depend on ld_valid_i.
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_last_i;
    logic        ld_ready_o;

    modport master (
        output ce_i, addr_i, ld_valid_i, ld_byte_i, ld_last_i,
        input  inst_o, ld_ready_o
    );

    modport slave (
        input  ce_i, addr_i, ld_valid_i, ld_byte_i, ld_last_i,
        output inst_o, ld_ready_o
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction memory filled by a big-endian byte stream at start-up; holds the
// core in reset until the image is complete, then serves fetches.
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    inst_rom_loader_if.slave    bus,
    output logic                loaded_o,
    output logic [ADDR_W:0]     load_words_o,
    output logic                cpu_rst_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q;
    logic [31:0]         asm_q;
    logic [ADDR_W-1:0]   wptr_q;
    logic [ADDR_W:0]     words_q;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                commit;
    logic [31:0]         word_d;
    logic [ADDR_W-1:0]   rd_idx;
    logic                unused_addr;

    assign accept = bus.ld_valid_i && (state_q == LOAD);
    assign commit = accept && ((byte_cnt_q == 2'd3) || bus.ld_last_i);

    // asm_q keeps unfilled lower bytes at zero, so a short last word comes out padded.
    always_comb begin
        word_d = asm_q;
        case (byte_cnt_q)
            2'd0: word_d[31:24] = bus.ld_byte_i;
            2'd1: word_d[23:16] = bus.ld_byte_i;
            2'd2: word_d[15:8]  = bus.ld_byte_i;
            default: word_d[7:0] = bus.ld_byte_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == LOAD && commit && (bus.ld_last_i || words_q == LAST_CNT)) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            wptr_q     <= '0;
            words_q    <= '0;
        end else if (accept) begin
            if (commit) begin
                byte_cnt_q <= 2'd0;
                asm_q      <= 32'd0;
                wptr_q     <= wptr_q + ADDR_W'(1);
                words_q    <= words_q + (ADDR_W + 1)'(1);
            end else begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                asm_q      <= word_d;
            end
        end
    end

    // Array has no reset: a new load simply overwrites, and words_q masks stale entries.
    always_ff @(posedge clk) begin
        if (rst && commit) begin
            mem[wptr_q] <= word_d;
        end
    end

    assign rd_idx      = bus.addr_i[ADDR_W+1:2];
    assign unused_addr = ^bus.addr_i[1:0];

    // A word committing this cycle is not yet counted, so it reads as zero until next cycle.
    always_comb begin
        bus.inst_o = 32'd0;
        if (bus.ce_i && (bus.addr_i[31:ADDR_W+2] == '0) && ({1'b0, rd_idx} < words_q)) begin
            bus.inst_o = mem[rd_idx];
        end
    end

    assign bus.ld_ready_o = (state_q == LOAD);
    assign cpu_rst_o      = (state_q == LOAD);
    assign loaded_o       = (state_q == RUN);
    assign load_words_o   = words_q;
endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader against a byte-queue image model.
module tb_inst_rom_loader;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          loaded;
    logic [AW:0]   load_words;
    logic          cpu_rst;

    inst_rom_loader_if bus();

    inst_rom_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .loaded_o     (loaded),
        .load_words_o (load_words),
        .cpu_rst_o    (cpu_rst)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_mem [DEPTH];
    int          exp_words;
    bit          exp_run;
    logic [7:0]  pend_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_inst(input bit ce, input logic [31:0] addr);
        int idx;
        if (!ce) return 32'd0;
        if ((addr >> (AW + 2)) != 0) return 32'd0;
        idx = int'(addr >> 2);
        if (idx >= exp_words) return 32'd0;
        return exp_mem[idx];
    endfunction

    // Image model: bytes pile up in order; every 4 bytes or a last byte make one word.
    function automatic void mdl_byte(input logic [7:0] b, input bit last);
        logic [31:0] w;
        pend_q.push_back(b);
        if (pend_q.size() == 4 || last) begin
            w = 32'd0;
            for (int i = 0; i < pend_q.size(); i++) begin
                w = w | (32'(pend_q[i]) << (24 - 8 * i));
            end
            exp_mem[exp_words] = w;
            exp_words++;
            pend_q.delete();
            if (last || exp_words == DEPTH) exp_run = 1'b1;
        end
    endfunction

    function automatic void mdl_reset();
        exp_words = 0;
        exp_run   = 1'b0;
        pend_q.delete();
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_words"}, 32'(load_words), 32'(exp_words));
        check({tag, "_loaded"}, 32'(loaded), 32'(exp_run));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_run));
        check({tag, "_ready"}, 32'(bus.ld_ready_o), 32'(!exp_run));
    endtask

    task automatic probe(input bit ce, input logic [31:0] addr, input string tag);
        @(negedge clk);
        bus.ce_i   = ce;
        bus.addr_i = addr;
        #1;
        check(tag, bus.inst_o, exp_inst(ce, addr));
    endtask

    // One clock: drive loader inputs, check a fetch and status before the edge, then update the model.
    task automatic cycle_byte(input bit valid, input logic [7:0] b, input bit last);
        logic [31:0] addr;
        @(negedge clk);
        bus.ld_valid_i = valid;
        bus.ld_byte_i  = b;
        bus.ld_last_i  = last;
        if ($urandom_range(0, 1) == 1)
            addr = 32'(exp_words * 4) + 32'($urandom_range(0, 3));
        else
            addr = 32'($urandom_range(0, exp_words + 1) * 4);
        bus.ce_i   = 1'b1;
        bus.addr_i = addr;
        #1;
        check("rd_during_load", bus.inst_o, exp_inst(1'b1, addr));
        check_status("cyc");
        @(posedge clk);
        if (valid && !exp_run) mdl_byte(b, last);
    endtask

    task automatic send(input logic [7:0] b, input bit last, input int max_gap);
        repeat ($urandom_range(0, max_gap)) cycle_byte(1'b0, 8'($urandom), 1'($urandom));
        cycle_byte(1'b1, b, last);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b0;
        bus.ld_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        mdl_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_status("reset");
    endtask

    task automatic verify_all(input string tag);
        for (int i = 0; i <= exp_words; i++) probe(1'b1, 32'(i * 4), tag);
    endtask

    logic [7:0] img1 [8];
    logic [7:0] img2 [6];
    int         len;

    initial begin
        rst            = 1'b0;
        bus.ce_i       = 1'b0;
        bus.addr_i     = 32'd0;
        bus.ld_valid_i = 1'b0;
        bus.ld_byte_i  = 8'd0;
        bus.ld_last_i  = 1'b0;
        mdl_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_status("por");
        check("por_words_const", 32'(load_words), 32'd0);

        img1 = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
        for (int i = 0; i < 8; i++) send(img1[i], i == 7, 0);
        @(negedge clk);
        bus.ld_valid_i = 1'b0;
        check_status("t1");
        probe(1'b1, 32'h0, "t1_a0");
        check("t1_a0_const", bus.inst_o, 32'h34020001);
        probe(1'b1, 32'h4, "t1_a4");
        check("t1_a4_const", bus.inst_o, 32'h34030002);
        probe(1'b1, 32'h8, "t1_a8");
        check("t1_a8_const", bus.inst_o, 32'h0);

        do_reset();
        img2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        for (int i = 0; i < 6; i++) send(img2[i], i == 5, 3);
        @(negedge clk);
        bus.ld_valid_i = 1'b0;
        check_status("t2");
        check("t2_words_const", 32'(load_words), 32'd2);
        probe(1'b1, 32'h4, "t2_a4");
        check("t2_a4_const", bus.inst_o, 32'h11220000);
        probe(1'b1, 32'h0, "t2_a0");
        check("t2_a0_const", bus.inst_o, 32'hAABBCCDD);
        probe(1'b0, 32'h0, "t2_ce0");
        probe(1'b1, 32'h0000_1000, "t2_oor");
        probe(1'b1, 32'h5, "t2_mis");
        check("t2_mis_const", bus.inst_o, 32'h11220000);

        do_reset();
        send(8'h99, 1'b0, 0);
        send(8'h88, 1'b0, 0);
        do_reset();
        send(8'h12, 1'b0, 1);
        send(8'h34, 1'b0, 1);
        send(8'h56, 1'b0, 1);
        send(8'h78, 1'b1, 1);
        @(negedge clk);
        bus.ld_valid_i = 1'b0;
        check_status("t3");
        check("t3_words_const", 32'(load_words), 32'd1);
        probe(1'b1, 32'h0, "t3_w0");
        check("t3_w0_const", bus.inst_o, 32'h12345678);
        probe(1'b1, 32'h4, "t3_stale");

        for (int k = 0; k < 3; k++) begin
            do_reset();
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) send(8'($urandom), i == len - 1, 2);
            @(negedge clk);
            bus.ld_valid_i = 1'b0;
            check_status("rnd");
            verify_all("rnd_rd");
        end

        do_reset();
        for (int i = 0; i < DEPTH * 4; i++) send(8'($urandom), 1'b0, 0);
        @(negedge clk);
        check_status("full");
        check("full_words_const", 32'(load_words), 32'(DEPTH));
        cycle_byte(1'b1, 8'h5A, 1'b1);
        cycle_byte(1'b1, 8'hA5, 1'b0);
        @(negedge clk);
        bus.ld_valid_i = 1'b0;
        check_status("after_full");
        probe(1'b1, 32'h0000_0FFC, "full_top");
        for (int i = 0; i < 64; i++) probe(1'b1, 32'($urandom_range(0, 4095)), "full_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder on the CPU side of the fetch interface. The core drives chip-enable and a byte PC; this block returns the 32-bit instruction word.
- The memory is filled at start-up through a byte-serial valid/ready loader port.
- It holds the core in reset until loading completes, then releases it.
- It sits beside the core in the SoC top, in place of a preinitialised ROM.

Parameters:
- ADDR_W, 10, word-address width; depth = 2^ADDR_W words (default 1024 words, 4 KiB).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- ce_i  input  1  fetch chip-enable from core.
- addr_i  input  32  fetch byte address (PC).
- inst_o  output  32  instruction word to core.
- ld_valid_i  input  1  loader byte valid.
- ld_byte_i  input  8  loader data byte.
- ld_last_i  input  1  marks final byte of image; qualified by the accept condition.
- ld_ready_o  output  1  loader may present a byte.
- loaded_o  output  1  image complete, core running.
- load_words_o  output  ADDR_W+1  number of committed words.
- cpu_rst_o  output  1  reset to core, active-high (core reset-enable level).

Behaviour:
- Reset (rst==0 at edge):
  - state=LOAD; byte_cnt=0; assembly register=0; wptr=0.
  - load_words_o=0; loaded_o=0; cpu_rst_o=1.
  - Memory array is not cleared.
- Reset mid-load: partial word discarded; previously written words masked (count=0).
- States:
  - LOAD: ld_ready_o=1, cpu_rst_o=1, loaded_o=0.
  - RUN: ld_ready_o=0, cpu_rst_o=0, loaded_o=1.
  - ld_ready_o is a decode of the registered state.
- Accept: a byte is accepted on an edge where ld_valid_i && ld_ready_o. Nothing is accepted in RUN.
- Assembly is big-endian:
  - byte_cnt 0 → bits[31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - byte_cnt increments mod 4 per accepted byte.
- Commit: on the accepting edge of byte_cnt==3, write the full word to mem[wptr]; wptr+1; load_words_o+1.
- Last byte: if ld_last_i on an accepted byte with byte_cnt<3:
  - unfilled lower bytes are zero;
  - the padded word is committed on the same edge;
  - load_words_o+1.
- LOAD→RUN transition: on the edge that commits with ld_last_i=1, OR on the commit that makes load_words_o == 2^ADDR_W (memory full).
  - A byte offered after full is never accepted, because ld_ready_o is already 0.
  - cpu_rst_o falls on the same edge state enters RUN.
  - First fetch is therefore visible the following cycle.
- RUN is left only by rst.
- Read path, combinational (core registers inst_o at its next edge):
  - ce_i==0 → inst_o=0.
  - addr_i[31:ADDR_W+2]!=0 (out of range) → 0.
  - word index addr_i[ADDR_W+1:2] >= load_words_o → 0 (NOP).
  - Otherwise inst_o = mem[index].
  - addr_i[1:0] ignored.
- Read/write collision: reading an index on the cycle it is being committed returns 0 (not yet counted); the new word is visible from the next cycle.
- Reads are legal in LOAD with identical rules.
- Width rules:
  - load_words_o is ADDR_W+1 bits so full depth is representable.
  - wptr wraps to 0 on full, but is unused after RUN.

Test Plan:
- Reset, then stream bytes 34 02 00 01, 34 03 00 02 with ld_last_i on the 8th → mem[0]=0x34020001, mem[1]=0x34030002, load_words_o=2, loaded_o=1, cpu_rst_o=0 on the edge accepting byte 8. With ce_i=1: addr 0x0→0x34020001, 0x4→0x34030002, 0x8→0x0.
- Image of 6 bytes AA BB CC DD 11 22 (last on 22) → mem[1]=0x11220000, load_words_o=2; ld_valid_i held high with gaps/backpressure: no byte lost or duplicated.
- ce_i=0 with addr 0x0 after load → inst_o=0. Out-of-range address 0x0000_1000 (ADDR_W=10) with ce_i=1 → 0. Misaligned 0x5 → mem[1].
- Fill all 1024 words without ld_last_i → RUN on 1024th commit, load_words_o=1024, ld_ready_o=0; a further valid byte is not accepted.
- Assert rst low after 2 bytes, release, and load one word with last → first word built only from post-reset bytes; load_words_o=1; stale words beyond index 0 read 0.
- Read the index being committed on the commit cycle → 0; next cycle → new word.
